// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - FSM state encoding (S_IDLE..S_ERROR), kept as plain localparams so
//     older code that compares raw state values keeps working
//   - frame-field byte counts (length prefix and checksum trailer)
//   - a helper that says which states take bytes from the stream
package imem_loader_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_LEN_LO = 3'd1;
    localparam logic [STATE_W-1:0] S_LEN_HI = 3'd2;
    localparam logic [STATE_W-1:0] S_DATA   = 3'd3;
    localparam logic [STATE_W-1:0] S_CHECK  = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd5;
    localparam logic [STATE_W-1:0] S_ERROR  = 3'd6;

    // Length prefix is a little-endian 16-bit byte count; checksum is one byte.
    localparam int LEN_FIELD_BYTES = 2;
    localparam int CHK_FIELD_BYTES = 1;
    localparam int LEN_FIELD_W     = 8 * LEN_FIELD_BYTES;
    localparam int CHK_FIELD_W     = 8 * CHK_FIELD_BYTES;

    // The loader is ready for a stream byte only while it is inside a frame.
    function automatic logic accepts_stream(input logic [STATE_W-1:0] s);
        return (s == S_LEN_LO) || (s == S_LEN_HI) ||
               (s == S_DATA)   || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader
// Loads a framed byte stream (LEN_LO, LEN_HI, N payload bytes, CHK) into the
// instruction-memory byte storage starting at address 0, and keeps the CPU
// held in reset until a frame has been loaded and its XOR checksum matched.
//
// Ports:
//   clk        core clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   start      begin a new load (honoured in IDLE, DONE or ERROR only)
//   in_valid   stream byte present
//   in_data    stream byte
//   in_ready   loader accepts in_data this cycle (decoded from state only)
//   mem_we     registered one-cycle byte write strobe
//   mem_addr   registered byte address of the write
//   mem_wdata  registered byte to write
//   cpu_hold   high keeps the CPU in reset with PC at 0
//   done       frame loaded and checksum matched
//   error      frame rejected (oversize length or checksum mismatch)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // The counter is one bit wider than the address so that a frame of
    // exactly 2^ADDR_WIDTH bytes can be counted to completion.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [STATE_W-1:0]     state;
    logic [7:0]             len_lo;
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       addr_cnt;
    logic [CNT_W-1:0]       addr_next;
    logic [CHK_FIELD_W-1:0] acc;
    logic [LEN_FIELD_W-1:0] frame_len;
    logic                   xfer;
    logic                   too_long;

    assign in_ready  = accepts_stream(state);
    assign xfer      = in_valid && in_ready;
    assign frame_len = {in_data, len_lo};
    assign addr_next = addr_cnt + CNT_W'(1);

    // Compare in 32 bits so the test works for any ADDR_WIDTH up to 31,
    // whether the counter is narrower or wider than the length field.
    assign too_long  = 32'(frame_len) > 32'(CAPACITY);

    // Frame FSM plus the registered memory-port and status outputs.
    // mem_we defaults low every cycle so each accepted payload byte gives
    // exactly one write pulse; mem_addr/mem_wdata simply hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_lo    <= '0;
            len_q     <= '0;
            addr_cnt  <= '0;
            acc       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LEN_LO;
                        acc      <= '0;
                        addr_cnt <= '0;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= in_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        if (too_long) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else if (frame_len == '0) begin
                            state <= S_CHECK;
                        end else begin
                            // Truncation is safe: too_long already excluded
                            // anything that does not fit in CNT_W bits.
                            len_q <= CNT_W'(frame_len);
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_cnt[ADDR_WIDTH-1:0];
                        mem_wdata <= in_data;
                        acc       <= acc ^ in_data;
                        addr_cnt  <= addr_next;
                        if (addr_next == len_q) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (in_data == acc) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. Frames with random payloads are driven
// over the valid/ready stream; a reference model built from the frame rules
// (XOR of the payload, capacity limit) predicts the status outputs, the number
// and addresses of memory writes, and the final memory contents.
module tb_imem_loader;

    localparam int AW      = 10;
    localparam int CAP     = 1 << AW;
    localparam int LOG_MAX = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] pl [0:CAP];
    logic [7:0] captured [0:CAP-1];
    int         wr_log [0:LOG_MAX-1];
    int         wr_count = 0;
    int         frame_base = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    // Behaves like the instruction-memory byte write port and logs every
    // write address in order.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            captured[mem_addr] <= mem_wdata;
            if (wr_count < LOG_MAX) wr_log[wr_count] <= int'(mem_addr);
            wr_count <= wr_count + 1;
        end
    end

    // Hard stop in case a bounded wait is somehow bypassed.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xorOf(input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) x = x ^ pl[i];
        return x;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fillRandom(input int n);
        for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) nextCycle();
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            nextCycle();
            t++;
        end
        if (in_ready !== 1'b1) checkOutput("ready_wait", 32'(in_ready), 32'd1);
        nextCycle();
        in_valid = 1'b0;
    endtask

    // Pulses start, then drives the length, payload and checksum. Oversize
    // frames stop after the length, since the loader rejects them there.
    task automatic applyStimulus(input int n, input logic [7:0] chk, input int gap);
        frame_base = wr_count;
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        checkOutput("ready_after_start", 32'(in_ready), 32'd1);
        checkOutput("hold_after_start", 32'(cpu_hold), 32'd1);
        checkOutput("done_after_start", 32'(done), 32'd0);
        checkOutput("error_after_start", 32'(error), 32'd0);
        sendByte(8'(n), gap);
        sendByte(8'(n >> 8), gap);
        if (n <= CAP) begin
            for (int i = 0; i < n; i++) sendByte(pl[i], gap);
            sendByte(chk, gap);
        end
    endtask

    // Called right after the last accepted byte of a frame.
    task automatic checkFrame(input int n, input logic [7:0] chk);
        logic fits;
        logic ok;
        int   exp_writes;
        int   bad;
        fits       = (n <= CAP);
        ok         = fits && (chk == xorOf(n));
        exp_writes = fits ? n : 0;
        checkOutput("done", 32'(done), 32'(ok));
        checkOutput("error", 32'(error), 32'(!ok));
        checkOutput("cpu_hold", 32'(cpu_hold), 32'(!ok));
        checkOutput("ready_after_frame", 32'(in_ready), 32'd0);
        repeat (2) nextCycle();
        checkOutput("write_count", 32'(wr_count - frame_base), 32'(exp_writes));
        bad = 0;
        for (int i = 0; i < exp_writes; i++)
            if (frame_base + i < LOG_MAX && wr_log[frame_base + i] != i) bad++;
        checkOutput("write_addr_seq", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < exp_writes; i++)
            if (captured[i] !== pl[i]) bad++;
        checkOutput("mem_contents", 32'(bad), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        int         n;
        logic [7:0] chk;
        logic [7:0] nominal [0:7];

        nominal = '{8'h04, 8'h00, 8'h10, 8'h8C, 8'h0C, 8'h00, 8'h11, 8'hAC};

        // Reset state
        rst_n = 1'b0;
        repeat (3) nextCycle();
        checkResetValues("reset");
        rst_n = 1'b1;
        nextCycle();

        // Nominal frame; the checksum is the XOR of the payload
        for (int i = 0; i < 8; i++) pl[i] = nominal[i];
        chk = xorOf(8);
        applyStimulus(8, chk, 0);
        checkFrame(8, chk);

        // Same payload with a zero checksum, which does not match
        applyStimulus(8, 8'h00, 0);
        checkFrame(8, 8'h00);

        // Backpressure: in_valid alternates low/high every cycle
        fillRandom(8);
        chk = xorOf(8);
        applyStimulus(8, chk, 1);
        checkFrame(8, chk);

        // Empty frame
        applyStimulus(0, 8'h00, 0);
        checkFrame(0, 8'h00);

        // Oversize length is rejected straight after LEN_HI
        applyStimulus(CAP + 1, 8'h00, 0);
        checkFrame(CAP + 1, 8'h00);

        // Reset in the middle of the payload
        fillRandom(8);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        sendByte(8'd8, 0);
        sendByte(8'd0, 0);
        for (int i = 0; i < 3; i++) sendByte(pl[i], 0);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        nextCycle();
        checkOutput("midreset_mem_we_next", 32'(mem_we), 32'd0);
        rst_n = 1'b1;
        nextCycle();
        fillRandom(16);
        chk = xorOf(16);
        applyStimulus(16, chk, 0);
        checkFrame(16, chk);

        // Frame that fills memory exactly
        fillRandom(CAP);
        chk = xorOf(CAP);
        applyStimulus(CAP, chk, 0);
        checkFrame(CAP, chk);

        // Random reloads, some with a corrupted checksum
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 64);
            fillRandom(n);
            chk = xorOf(n);
            if ($urandom_range(0, 1) == 1) chk = chk ^ 8'($urandom_range(1, 255));
            applyStimulus(n, chk, $urandom_range(0, 1));
            checkFrame(n, chk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
